// File: rtl/axis_pkt_byte_counter.sv
// AXI-Stream register slice that counts bytes per packet and emits one
// saturated length word per packet on a side channel, aligned with TLAST.

module tkeep_to_len #(
   parameter int KEEP_WIDTH = 8,
   parameter int ENC_W      = $clog2(KEEP_WIDTH)
) (
   input  logic [KEEP_WIDTH-1:0] tkeep_i,
   output logic [ENC_W-1:0]      len_o
);
   logic [ENC_W:0] pop;

   // Popcount-1 is exact for legal left-aligned keeps and harmless otherwise.
   always_comb begin
      pop = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) pop = pop + {{ENC_W{1'b0}}, tkeep_i[i]};
      len_o = ENC_W'(pop - 1'b1);
   end
endmodule

module axis_pkt_byte_counter #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [LEN_WIDTH-1:0]    len_tdata,
   output logic                    len_tuser,
   output logic                    len_tvalid,
   input  logic                    len_tready
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int ENC_W      = $clog2(KEEP_WIDTH);
   localparam int CNT_W      = ENC_W + 1;

   logic [ENC_W-1:0]      enc;
   logic [CNT_W-1:0]      cnt;
   logic [LEN_WIDTH:0]    sum;
   logic [LEN_WIDTH-1:0]  sat;
   logic                  acc_en;

   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
   logic                  m_last_q, m_last_d;
   logic                  m_valid_q, m_valid_d;
   logic [LEN_WIDTH-1:0]  len_data_q, len_data_d;
   logic                  len_user_q, len_user_d;
   logic                  len_valid_q, len_valid_d;
   logic [LEN_WIDTH-1:0]  acc_q, acc_d;
   logic                  ovf_q, ovf_d;

   tkeep_to_len #(.KEEP_WIDTH(KEEP_WIDTH), .ENC_W(ENC_W)) u_enc (
      .tkeep_i (s_axis_tkeep),
      .len_o   (enc)
   );

   assign cnt = {1'b0, enc} + CNT_W'(1);
   assign sum = {1'b0, acc_q} + (LEN_WIDTH+1)'(cnt);
   assign sat = sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];

   // A pending length word stalls every beat, not just the next TLAST.
   assign s_axis_tready = (!m_valid_q || m_axis_tready) && (!len_valid_q || len_tready);
   assign acc_en        = s_axis_tvalid && s_axis_tready;

   always_comb begin
      m_data_d    = m_data_q;
      m_keep_d    = m_keep_q;
      m_last_d    = m_last_q;
      m_valid_d   = m_valid_q;
      len_data_d  = len_data_q;
      len_user_d  = len_user_q;
      len_valid_d = len_valid_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;
      if (len_valid_q && len_tready)  len_valid_d = 1'b0;
      if (acc_en) begin
         m_data_d  = s_axis_tdata;
         m_keep_d  = s_axis_tkeep;
         m_last_d  = s_axis_tlast;
         m_valid_d = 1'b1;
         if (s_axis_tlast) begin
            len_data_d  = sat;
            len_user_d  = ovf_q | sum[LEN_WIDTH];
            len_valid_d = 1'b1;
            acc_d       = '0;
            ovf_d       = 1'b0;
         end else begin
            acc_d = sat;
            ovf_d = ovf_q | sum[LEN_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_data_q    <= '0;
         m_keep_q    <= '0;
         m_last_q    <= 1'b0;
         m_valid_q   <= 1'b0;
         len_data_q  <= '0;
         len_user_q  <= 1'b0;
         len_valid_q <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         m_data_q    <= m_data_d;
         m_keep_q    <= m_keep_d;
         m_last_q    <= m_last_d;
         m_valid_q   <= m_valid_d;
         len_data_q  <= len_data_d;
         len_user_q  <= len_user_d;
         len_valid_q <= len_valid_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tvalid = m_valid_q;
   assign len_tdata     = len_data_q;
   assign len_tuser     = len_user_q;
   assign len_tvalid    = len_valid_q;
endmodule

// File: tb/tb_axis_pkt_byte_counter.sv
// Scoreboard bench: two instances (LEN_WIDTH 16 and 4) share one stimulus stream.

module tb_axis_pkt_byte_counter;
   localparam int DW = 64;
   localparam int KW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          s_tlast, s_tvalid;
   logic          m_tready, len_tready;

   logic          s_tready, s_tready4;
   logic [DW-1:0] m_tdata, m_tdata4;
   logic [KW-1:0] m_tkeep, m_tkeep4;
   logic          m_tlast, m_tlast4, m_tvalid, m_tvalid4;
   logic [15:0]   len16;
   logic [3:0]    len4;
   logic          user16, user4, lvalid16, lvalid4;

   always #5 clk = ~clk;

   axis_pkt_byte_counter #(.DATA_WIDTH(DW), .LEN_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .len_tdata(len16), .len_tuser(user16), .len_tvalid(lvalid16), .len_tready(len_tready)
   );

   axis_pkt_byte_counter #(.DATA_WIDTH(DW), .LEN_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready4),
      .m_axis_tdata(m_tdata4), .m_axis_tkeep(m_tkeep4), .m_axis_tlast(m_tlast4),
      .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready),
      .len_tdata(len4), .len_tuser(user4), .len_tvalid(lvalid4), .len_tready(len_tready)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [31:0]   cyc;
   } beat_t;

   typedef struct packed {
      logic [15:0] len;
      logic        user;
      logic        dc;
   } len_t;

   beat_t dq[$];
   len_t  lq16[$], lq4[$];

   int n_chk = 0, n_err = 0;
   int n_pkts = 0, n_len16 = 0, n_len4 = 0;
   logic [31:0] cyc = 0;
   int unsigned tot = 0;
   logic pkt_dc = 1'b0;
   logic flush = 1'b1;
   logic rnd = 1'b0;
   logic [15:0] last_len16 = 0, prev_len16 = 0;
   logic [15:0] last_len4 = 0;
   logic        last_user16 = 0, last_user4 = 0;
   logic [31:0] len_cyc_last = 0, len_cyc_prev = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (rnd) begin
      #1;
      m_tready   = 1'($urandom_range(0, 1));
      len_tready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- driver + reference model ----------------
   function automatic logic legal_keep(input logic [KW-1:0] k);
      logic [KW-1:0] ones = '1;
      legal_keep = 1'b0;
      for (int n = 0; n < KW; n++) if (k == (ones << n)) legal_keep = 1'b1;
   endfunction

   // Entered and left at posedge+1.
   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      int   n = 0;
      len_t e;
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
      forever begin
         @(negedge clk);
         if (s_tready && s_tready4) break;
         n++;
         if (n > 2000) begin
            chk("s_tready_timeout", 1, 0);
            $fatal(1, "FAIL input stalled forever");
         end
      end
      dq.push_back('{data: d, keep: k, last: l, cyc: cyc});
      tot += $countones(k);
      if (!legal_keep(k)) pkt_dc = 1'b1;
      if (l) begin
         e.dc = pkt_dc;
         e.len = (tot > 65535) ? 16'hFFFF : 16'(tot);
         e.user = (tot > 65535);
         lq16.push_back(e);
         e.len = (tot > 15) ? 16'd15 : 16'(tot);
         e.user = (tot > 15);
         lq4.push_back(e);
         tot = 0; pkt_dc = 1'b0; n_pkts++;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
   endtask

   task automatic send_rand_pkt();
      int nb = $urandom_range(1, 5);
      logic [KW-1:0] ones = '1;
      for (int b = 0; b < nb; b++)
         send_beat({$urandom, $urandom}, ones << $urandom_range(0, KW-1), b == nb-1);
   endtask

   task automatic drain();
      int n = 0;
      while ((dq.size() != 0 || lq16.size() != 0 || lq4.size() != 0) && n < 3000) begin
         @(negedge clk); n++;
      end
      chk("drain_done", (n < 3000), 1);
      @(posedge clk); #1;
   endtask

   // ---------------- monitor (samples at negedge) ----------------
   logic            m_stall = 0, l_stall = 0;
   logic [DW+KW:0]  m_prev;
   logic [20:0]     l_prev;

   always @(negedge clk) begin
      beat_t b;
      len_t  e;
      if (!flush) begin
         if (m_tvalid) begin
            chk("m_valid4", m_tvalid4, 1);
            if (m_stall) chk("m_stable", {m_tdata, m_tkeep, m_tlast}, m_prev);
            else if (dq.size() == 0) chk("m_spurious", 1, 0);
            else begin
               chk("m_latency", cyc, dq[0].cyc + 1);
               if (m_tlast) chk("len_with_last", {lvalid16, lvalid4}, 2'b11);
            end
            if (m_tready && dq.size() != 0) begin
               b = dq.pop_front();
               chk("m_data", m_tdata, b.data);
               chk("m_keep", m_tkeep, b.keep);
               chk("m_last", m_tlast, b.last);
               chk("m_data4", {m_tdata4, m_tkeep4, m_tlast4}, {b.data, b.keep, b.last});
            end
         end
         if (lvalid16) begin
            if (l_stall) chk("len_stable", {len16, user16, len4, user4}, l_prev);
            if (len_tready) begin
               if (lq16.size() == 0 || lq4.size() == 0) chk("len_spurious", 1, 0);
               else begin
                  e = lq16.pop_front();
                  if (!e.dc) begin
                     chk("len16", len16, e.len);
                     chk("user16", user16, e.user);
                  end
                  e = lq4.pop_front();
                  if (!e.dc) begin
                     chk("len4", len4, e.len[3:0]);
                     chk("user4", user4, e.user);
                  end
               end
               n_len16++;
               if (lvalid4) n_len4++;
               prev_len16 = last_len16; last_len16 = len16; last_user16 = user16;
               last_len4 = {12'd0, len4}; last_user4 = user4;
               len_cyc_prev = len_cyc_last; len_cyc_last = cyc;
            end
         end
      end
      m_stall = m_tvalid && !m_tready;
      m_prev  = {m_tdata, m_tkeep, m_tlast};
      l_stall = lvalid16 && !len_tready;
      l_prev  = {len16, user16, len4, user4};
   end

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1; s_tvalid = 0; s_tdata = 0; s_tkeep = 0; s_tlast = 0;
      m_tready = 1'b1; len_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_m_valid", {m_tvalid, m_tvalid4}, 0);
      chk("rst_len_valid", {lvalid16, lvalid4}, 0);
      chk("rst_len", {len16, user16, len4, user4}, 0);
      chk("rst_m_bus", {m_tdata, m_tkeep, m_tlast}, 0);
      flush = 1'b0;
      @(posedge clk); #1;

      // basic 3-beat packet
      send_beat(64'h0001_0203_0405_0607, 8'hFF, 0);
      send_beat(64'h1011_1213_1415_1617, 8'hFF, 0);
      send_beat(64'h2021_2223_0000_0000, 8'hF0, 1);
      @(negedge clk); chk("basic_len_pulse_hi", lvalid16, 1);
      @(negedge clk); chk("basic_len_pulse_lo", lvalid16, 0);
      @(posedge clk); #1;
      drain();
      chk("basic_len", {last_len16, last_user16}, {16'd20, 1'b0});

      // single-beat minimum, then back-to-back singles
      send_beat(64'hAA00_0000_0000_0000, 8'h80, 1);
      drain();
      chk("min_len", last_len16, 1);
      send_beat(64'h1122_3344_5566_7788, 8'hFF, 1);
      send_beat(64'h99AA_0000_0000_0000, 8'hC0, 1);
      drain();
      chk("b2b_lens", {prev_len16, last_len16}, {16'd8, 16'd2});
      chk("b2b_gap", len_cyc_last - len_cyc_prev, 1);

      // length-channel backpressure
      len_tready = 1'b0;
      send_beat(64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, 0);
      send_beat(64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, 1);
      fork
         begin
            send_beat(64'hB0B0_B0B0_B0B0_B0B0, 8'hFF, 0);
            send_beat(64'hB1B1_B1B1_B100_0000, 8'hF8, 1);
         end
         begin
            repeat (4) begin
               @(negedge clk);
               chk("bp_s_tready", s_tready, 0);
               chk("bp_len_hold", {lvalid16, len16}, {1'b1, 16'd16});
            end
            @(posedge clk); #1 len_tready = 1'b1;
         end
      join
      drain();
      chk("bp_len_b", {prev_len16, last_len16}, {16'd16, 16'd13});

      // saturation on the 4-bit instance
      send_beat(64'h1, 8'hFF, 0);
      send_beat(64'h2, 8'hFF, 0);
      send_beat(64'h3, 8'hFF, 1);
      drain();
      chk("sat_len4", {last_len4, last_user4}, {16'd15, 1'b1});
      chk("sat_len16", last_len16, 24);
      send_beat(64'h4, 8'hE0, 1);
      drain();
      chk("sat_clear4", {last_len4, last_user4}, {16'd3, 1'b0});

      // random traffic under random backpressure
      rnd = 1'b1;
      for (int p = 0; p < 100; p++) send_rand_pkt();
      rnd = 1'b0;
      @(posedge clk); #2;
      m_tready = 1'b1; len_tready = 1'b1;
      drain();
      chk("rand_len_count16", n_len16, n_pkts);
      chk("rand_len_count4", n_len4, n_pkts);

      // reset mid-packet
      send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 0);
      send_beat(64'hDEAD_BEEF_0000_0002, 8'hFF, 0);
      flush = 1'b1; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      dq.delete(); lq16.delete(); lq4.delete();
      tot = 0; pkt_dc = 1'b0;
      @(negedge clk);
      chk("midrst_valids", {m_tvalid, m_tvalid4, lvalid16, lvalid4}, 0);
      chk("midrst_len", {len16, user16}, 0);
      flush = 1'b0;
      @(posedge clk); #1;
      send_beat(64'hFCFC_FCFC_FCFC_0000, 8'hFC, 1);
      drain();
      chk("midrst_new_len", last_len16, 6);

      // illegal keep: data still forwarded, no deadlock
      send_beat(64'h0BAD_0000_0000_0001, 8'h00, 0);
      send_beat(64'h0BAD_0000_0000_0002, 8'h5A, 1);
      send_beat(64'h0C0C_0C00_0000_0000, 8'hE0, 1);
      drain();
      chk("post_illegal_len", last_len16, 3);
      chk("final_len_count", n_len16, n_pkts);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
